retospect_cfg_loader: RTL

Serializer that drives the neurochip configuration shift chain. It accepts configuration bytes from a host over a valid/ready handshake and shifts them LSB-first into the chain's `bs_in`, asserting the chain's `config_en` only while a bit is being shifted. It sits between the host byte interface and the daisy chain formed by the clockbox and the CNB array. An optional readback path compares the bits returned from the chain's `bs_out` against the stream being sent.

---
 rtl/retospect_cfg_loader_if.sv | 19 +
 rtl/retospect_cfg_loader.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/retospect_cfg_loader_if.sv
// Host-side byte handshake for the configuration chain loader.
// The master (host) offers bytes; the slave (loader) signals ready.
interface retospect_cfg_loader_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/retospect_cfg_loader.sv
// Byte-to-bit serializer for the neurochip configuration shift chain.
// Optional readback compare enabled by RETOSPECT_CFG_READBACK_EN.
module retospect_cfg_loader #(
    parameter int CHAIN_LEN = 523,
    parameter int CNT_W     = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    retospect_cfg_loader_if.slave  host,
    output logic                   config_en,
    output logic                   bs_out,
    input  logic                   bs_ret,
    output logic                   busy,
    output logic                   done,
    output logic                   mismatch
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN);

    state_t           state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]       sub_cnt_q, sub_cnt_d;
    logic             config_en_q, config_en_d;
    logic             bs_out_q, bs_out_d;
    logic             byte_ready_q, byte_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mismatch_q, mismatch_d;

`ifndef RETOSPECT_CFG_READBACK_EN
    logic unused_bs_ret;
    assign unused_bs_ret = bs_ret;
`endif

    // Next-state and next-output computation for the load sequencer.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        sub_cnt_d    = sub_cnt_q;
        bs_out_d     = bs_out_q;
        mismatch_d   = mismatch_q;
        config_en_d  = 1'b0;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bit_cnt_d  = '0;
                    mismatch_d = 1'b0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (host.byte_valid && byte_ready_q) begin
                    shreg_d   = host.byte_data;
                    sub_cnt_d = 4'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                bs_out_d    = shreg_q[0];
                config_en_d = 1'b1;
                shreg_d     = {1'b0, shreg_q[7:1]};
                bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                sub_cnt_d   = sub_cnt_q + 4'd1;
                if (bit_cnt_d == LAST) begin
                    state_d = DONE;
                end else if (sub_cnt_d == 4'd8) begin
                    state_d = LOAD;
                end
            end
            DONE: begin
                // First DONE cycle carries the last chain bit; the
                // second raises the done pulse, then we drop to IDLE.
                if (!done_q) begin
                    done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef RETOSPECT_CFG_READBACK_EN
        if (config_en_q && (bs_ret != bs_out_q)) begin
            mismatch_d = 1'b1;
        end
`else
        mismatch_d = 1'b0;
`endif

        byte_ready_d = (state_d == LOAD);
        busy_d       = (state_d != IDLE);
    end

    // State and registered outputs; async reset leaves the chain as-is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            sub_cnt_q    <= '0;
            config_en_q  <= 1'b0;
            bs_out_q     <= 1'b0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mismatch_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            sub_cnt_q    <= sub_cnt_d;
            config_en_q  <= config_en_d;
            bs_out_q     <= bs_out_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mismatch_q   <= mismatch_d;
        end
    end

    assign host.byte_ready = byte_ready_q;
    assign config_en       = config_en_q;
    assign bs_out          = bs_out_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign mismatch        = mismatch_q;

endmodule
